mem_port_arbiter: RTL and testbench

//  Merges the CPU's split instruction and data memory ports onto one shared memory port.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package arbiter_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_side_t;

  // On a tie the side that did not win last time gets the port.
  function automatic arb_side_t pick_side(input logic pend_i, input logic pend_d,
                                          input arb_side_t last_grant);
    arb_side_t side;
    if (pend_i && pend_d) begin
      side = (last_grant == INST) ? DATA : INST;
    end else if (pend_d) begin
      side = DATA;
    end else begin
      side = INST;
    end
    return side;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Merges split instruction/data memory ports onto one shared port, one transaction at a time.
// The granted request is latched so the shared port never sees requester input changes.
module mem_port_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   inst_mem_address,
  input  logic                    inst_mem_read,
  input  logic                    inst_mem_write,
  input  logic [DATA_WIDTH/8-1:0] inst_mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   inst_mem_wdata,
  output logic [DATA_WIDTH-1:0]   inst_mem_rdata,
  output logic                    inst_mem_resp,
  input  logic [ADDR_WIDTH-1:0]   data_mem_address,
  input  logic                    data_mem_read,
  input  logic                    data_mem_write,
  input  logic [DATA_WIDTH/8-1:0] data_mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   data_mem_wdata,
  output logic [DATA_WIDTH-1:0]   data_mem_rdata,
  output logic                    data_mem_resp,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  arb_state_t              state_r, state_s;
  arb_side_t               last_grant_r, last_grant_s;
  arb_side_t               sel_s;
  logic                    latch_s;
  logic                    serving_s;
  logic                    pend_i_s, pend_d_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    read_r, write_r;
  logic [BE_WIDTH-1:0]     be_r;
  logic [DATA_WIDTH-1:0]   wdata_r;

  // Next-state, grant selection and all port outputs.
  always_comb begin
    pend_i_s     = inst_mem_read | inst_mem_write;
    pend_d_s     = data_mem_read | data_mem_write;
    sel_s        = pick_side(pend_i_s, pend_d_s, last_grant_r);
    state_s      = state_r;
    last_grant_s = last_grant_r;
    latch_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_i_s || pend_d_s) begin
          latch_s = 1'b1;
          state_s = (sel_s == DATA) ? SERVE_D : SERVE_I;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_s      = IDLE;
          last_grant_s = INST;
        end else begin
          state_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_s      = IDLE;
          last_grant_s = DATA;
        end else begin
          state_s = SERVE_D;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Shared port is a pure decode of registered state; rst forces everything quiet.
    serving_s       = !rst && ((state_r == SERVE_I) || (state_r == SERVE_D));
    mem_address     = serving_s ? addr_r : {ADDR_WIDTH{1'b0}};
    mem_read        = serving_s & read_r;
    mem_write       = serving_s & write_r;
    mem_byte_enable = serving_s ? be_r : {BE_WIDTH{1'b0}};
    mem_wdata       = serving_s ? wdata_r : {DATA_WIDTH{1'b0}};
    inst_mem_resp   = !rst && (state_r == SERVE_I) && mem_resp;
    data_mem_resp   = !rst && (state_r == SERVE_D) && mem_resp;
    inst_mem_rdata  = inst_mem_resp ? mem_rdata : {DATA_WIDTH{1'b0}};
    data_mem_rdata  = data_mem_resp ? mem_rdata : {DATA_WIDTH{1'b0}};
  end

  // State, last winner and the request fields captured in the grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= INST;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      be_r         <= {BE_WIDTH{1'b0}};
      wdata_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      if (latch_s) begin
        // Read and write together is treated as a write.
        if (sel_s == DATA) begin
          addr_r  <= data_mem_address;
          read_r  <= data_mem_read & ~data_mem_write;
          write_r <= data_mem_write;
          be_r    <= data_mem_byte_enable;
          wdata_r <= data_mem_wdata;
        end else begin
          addr_r  <= inst_mem_address;
          read_r  <= inst_mem_read & ~inst_mem_write;
          write_r <= inst_mem_write;
          be_r    <= inst_mem_byte_enable;
          wdata_r <= inst_mem_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester agents, a latency-programmable memory
// responder, and one monitor that pops expected shared-port and response entries.
module tb_mem_port_arbiter;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chg;
    logic [31:0] chg_addr;
  } req_t;

  typedef struct {
    int          side;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
  } mexp_t;

  typedef struct {
    int          side;
    logic [31:0] rdata;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_mem_address = 32'h0;
  logic        inst_mem_read = 1'b0;
  logic        inst_mem_write = 1'b0;
  logic [3:0]  inst_mem_byte_enable = 4'h0;
  logic [31:0] inst_mem_wdata = 32'h0;
  logic [31:0] inst_mem_rdata;
  logic        inst_mem_resp;
  logic [31:0] data_mem_address = 32'h0;
  logic        data_mem_read = 1'b0;
  logic        data_mem_write = 1'b0;
  logic [3:0]  data_mem_byte_enable = 4'h0;
  logic [31:0] data_mem_wdata = 32'h0;
  logic [31:0] data_mem_rdata;
  logic        data_mem_resp;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_resp = 1'b0;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    i_issue = 0, d_issue = 0;
  int    i_to = 0, d_to = 0, main_to = 0;
  bit    i_busy = 1'b0, d_busy = 1'b0;
  int    resp_lat = 3;
  bit    force_resp = 1'b0;
  bit    end_req = 1'b0, end_done = 1'b0;
  req_t  iq[$];
  req_t  dq[$];
  mexp_t exp_mem[$];
  rexp_t exp_resp[$];

  bit          prev_active = 1'b0;
  bit          active;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic [1:0]  cap_op;
  mexp_t       me;
  rexp_t       re;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .inst_mem_address     (inst_mem_address),
    .inst_mem_read        (inst_mem_read),
    .inst_mem_write       (inst_mem_write),
    .inst_mem_byte_enable (inst_mem_byte_enable),
    .inst_mem_wdata       (inst_mem_wdata),
    .inst_mem_rdata       (inst_mem_rdata),
    .inst_mem_resp        (inst_mem_resp),
    .data_mem_address     (data_mem_address),
    .data_mem_read        (data_mem_read),
    .data_mem_write       (data_mem_write),
    .data_mem_byte_enable (data_mem_byte_enable),
    .data_mem_wdata       (data_mem_wdata),
    .data_mem_rdata       (data_mem_rdata),
    .data_mem_resp        (data_mem_resp),
    .mem_address          (mem_address),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_byte_enable      (mem_byte_enable),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_resp             (mem_resp)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction-side requester: holds each request until its resp, aborts on rst.
  initial begin
    req_t r;
    bit   got;
    forever begin
      @(posedge clk); #1;
      if (iq.size() > 0 && !rst) begin
        r = iq.pop_front();
        i_busy = 1'b1;
        inst_mem_read = r.rd; inst_mem_write = r.wr; inst_mem_address = r.addr;
        inst_mem_byte_enable = r.be; inst_mem_wdata = r.wdata;
        i_issue = cyc;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
          @(negedge clk);
          if (rst) break;
          if (inst_mem_resp) got = 1'b1;
          else if (k == 1 && r.chg) inst_mem_address = r.chg_addr;
        end
        if (!got && !rst) i_to++;
        i_busy = 1'b0;
      end else begin
        inst_mem_read = 1'b0; inst_mem_write = 1'b0; inst_mem_address = 32'h0;
        inst_mem_byte_enable = 4'h0; inst_mem_wdata = 32'h0;
      end
    end
  end

  // Data-side requester.
  initial begin
    req_t r;
    bit   got;
    forever begin
      @(posedge clk); #1;
      if (dq.size() > 0 && !rst) begin
        r = dq.pop_front();
        d_busy = 1'b1;
        data_mem_read = r.rd; data_mem_write = r.wr; data_mem_address = r.addr;
        data_mem_byte_enable = r.be; data_mem_wdata = r.wdata;
        d_issue = cyc;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
          @(negedge clk);
          if (rst) break;
          if (data_mem_resp) got = 1'b1;
          else if (k == 1 && r.chg) data_mem_address = r.chg_addr;
        end
        if (!got && !rst) d_to++;
        d_busy = 1'b0;
      end else begin
        data_mem_read = 1'b0; data_mem_write = 1'b0; data_mem_address = 32'h0;
        data_mem_byte_enable = 4'h0; data_mem_wdata = 32'h0;
      end
    end
  end

  // Memory model: answers resp_lat cycles after the request appears, rdata = address ^ 0x73.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_resp = 1'b0; mem_rdata = 32'h0; cnt = 0;
      end else if (mem_resp) begin
        mem_resp = 1'b0; mem_rdata = 32'h0;
      end else if (force_resp) begin
        mem_resp = 1'b1; mem_rdata = 32'hBAD0BAD0;
      end else if (mem_read || mem_write) begin
        if (cnt >= resp_lat) begin
          mem_resp = 1'b1; mem_rdata = mem_address ^ 32'h00000073; cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: all comparisons happen here.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_ctl", {30'h0, mem_read, mem_write}, 32'h0);
      chk("rst_mem_fields", mem_address | mem_wdata | {28'h0, mem_byte_enable}, 32'h0);
      chk("rst_resp", {30'h0, inst_mem_resp, data_mem_resp}, 32'h0);
      chk("rst_rdata", inst_mem_rdata | data_mem_rdata, 32'h0);
      prev_active = 1'b0;
    end else begin
      active = mem_read | mem_write;
      if (active && !prev_active) begin
        if (exp_mem.size() == 0) begin
          chk("unexpected_mem_txn", {31'h0, active}, 32'h0);
        end else begin
          me = exp_mem.pop_front();
          chk("mem_address", mem_address, me.addr);
          chk("mem_op", {30'h0, mem_read, mem_write}, {30'h0, me.rd, me.wr});
          chk("mem_byte_enable", {28'h0, mem_byte_enable}, {28'h0, me.be});
          chk("mem_wdata", mem_wdata, me.wdata);
          if (me.lat >= 0) chk("grant_latency", cyc - ((me.side == 0) ? i_issue : d_issue), me.lat);
        end
        cap_addr = mem_address; cap_wdata = mem_wdata;
        cap_be = mem_byte_enable; cap_op = {mem_read, mem_write};
      end else if (active) begin
        chk("hold_address", mem_address, cap_addr);
        chk("hold_op", {30'h0, mem_read, mem_write}, {30'h0, cap_op});
        chk("hold_data", mem_wdata ^ {28'h0, mem_byte_enable}, cap_wdata ^ {28'h0, cap_be});
      end else begin
        chk("idle_mem_fields", mem_address | mem_wdata | {28'h0, mem_byte_enable}, 32'h0);
      end
      prev_active = active;

      if (inst_mem_resp || data_mem_resp) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", {30'h0, inst_mem_resp, data_mem_resp}, 32'h0);
        end else begin
          re = exp_resp.pop_front();
          chk("resp_side", {30'h0, inst_mem_resp, data_mem_resp}, (re.side == 0) ? 32'h2 : 32'h1);
          chk("resp_rdata", (re.side == 0) ? inst_mem_rdata : data_mem_rdata, re.rdata);
          chk("other_rdata", (re.side == 0) ? data_mem_rdata : inst_mem_rdata, 32'h0);
        end
      end else begin
        chk("rdata_no_resp", inst_mem_rdata | data_mem_rdata, 32'h0);
      end
    end
    if (end_req && !end_done) begin
      chk("leftover_mem_exp", exp_mem.size(), 32'h0);
      chk("leftover_resp_exp", exp_resp.size(), 32'h0);
      chk("timeouts", i_to + d_to + main_to, 32'h0);
      end_done = 1'b1;
    end
    cyc++;
  end

  task automatic push_req(input int side, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input bit chg, input logic [31:0] chg_addr);
    req_t r;
    r = '{rd, wr, addr, be, wdata, chg, chg_addr};
    if (side == 0) iq.push_back(r);
    else dq.push_back(r);
  endtask

  task automatic exp_m(input int side, input logic [31:0] addr, input bit rd, input bit wr,
                       input logic [3:0] be, input logic [31:0] wdata, input int lat);
    mexp_t e;
    e = '{side, addr, rd, wr, be, wdata, lat};
    exp_mem.push_back(e);
  endtask

  task automatic exp_r(input int side, input logic [31:0] rdata);
    rexp_t e;
    e = '{side, rdata};
    exp_resp.push_back(e);
  endtask

  task automatic wait_quiet();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (iq.size() == 0 && dq.size() == 0 && exp_mem.size() == 0 &&
          exp_resp.size() == 0 && !i_busy && !d_busy) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    main_to++;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Lone instruction read.
    @(negedge clk);
    push_req(0, 1'b1, 1'b0, 32'h60, 4'hF, 32'h0, 1'b0, 32'h0);
    exp_m(0, 32'h60, 1'b1, 1'b0, 4'hF, 32'h0, 1);
    exp_r(0, 32'h00000013);
    wait_quiet();

    // Simultaneous requests straight after reset: data first, then one bubble, then inst.
    reset_pulse();
    @(negedge clk);
    push_req(0, 1'b1, 1'b0, 32'h64, 4'hF, 32'h0, 1'b0, 32'h0);
    push_req(1, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    exp_m(1, 32'h1000, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 1);
    exp_m(0, 32'h64, 1'b1, 1'b0, 4'hF, 32'h0, 6);
    exp_r(1, 32'h00001073);
    exp_r(0, 32'h00000017);
    wait_quiet();

    // Both sides held for six transactions: strict alternation D,I,D,I,D,I.
    resp_lat = 2;
    @(negedge clk);
    push_req(1, 1'b0, 1'b1, 32'h200, 4'b0001, 32'h11111111, 1'b0, 32'h0);
    push_req(1, 1'b1, 1'b0, 32'h204, 4'hF, 32'h0, 1'b0, 32'h0);
    push_req(1, 1'b0, 1'b1, 32'h208, 4'b1100, 32'h33333333, 1'b0, 32'h0);
    push_req(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 32'h0);
    push_req(0, 1'b1, 1'b0, 32'h104, 4'hF, 32'h0, 1'b0, 32'h0);
    push_req(0, 1'b1, 1'b0, 32'h108, 4'hF, 32'h0, 1'b0, 32'h0);
    exp_m(1, 32'h200, 1'b0, 1'b1, 4'b0001, 32'h11111111, 1);
    exp_m(0, 32'h100, 1'b1, 1'b0, 4'hF, 32'h0, -1);
    exp_m(1, 32'h204, 1'b1, 1'b0, 4'hF, 32'h0, -1);
    exp_m(0, 32'h104, 1'b1, 1'b0, 4'hF, 32'h0, -1);
    exp_m(1, 32'h208, 1'b0, 1'b1, 4'b1100, 32'h33333333, -1);
    exp_m(0, 32'h108, 1'b1, 1'b0, 4'hF, 32'h0, -1);
    exp_r(1, 32'h00000273);
    exp_r(0, 32'h00000173);
    exp_r(1, 32'h00000277);
    exp_r(0, 32'h00000177);
    exp_r(1, 32'h0000027B);
    exp_r(0, 32'h0000017B);
    wait_quiet();

    // Read and write together become a write.
    resp_lat = 3;
    @(negedge clk);
    push_req(1, 1'b1, 1'b1, 32'h2000, 4'b0011, 32'hCAFEF00D, 1'b0, 32'h0);
    exp_m(1, 32'h2000, 1'b0, 1'b1, 4'b0011, 32'hCAFEF00D, 1);
    exp_r(1, 32'h00002073);
    wait_quiet();

    // Address changed by the requester mid-transaction must not reach the shared port.
    resp_lat = 4;
    @(negedge clk);
    push_req(0, 1'b1, 1'b0, 32'h80, 4'hF, 32'h0, 1'b1, 32'h84);
    exp_m(0, 32'h80, 1'b1, 1'b0, 4'hF, 32'h0, 1);
    exp_r(0, 32'h000000F3);
    wait_quiet();

    // Reset two cycles into a data transaction, then a stray mem_resp while idle.
    resp_lat = 20;
    @(negedge clk);
    push_req(1, 1'b1, 1'b0, 32'h3000, 4'hF, 32'h0, 1'b0, 32'h0);
    exp_m(1, 32'h3000, 1'b1, 1'b0, 4'hF, 32'h0, 1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_read) seen = 1'b1;
    end
    if (!seen) main_to++;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 force_resp = 1'b1;
    @(posedge clk); #2 force_resp = 1'b0;
    repeat (4) @(negedge clk);

    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_done; k++) @(posedge clk);
    if (!end_done) begin
      vectors++;
      miscompares++;
      $display("FAIL final_check: got 0x0 expected 0x1");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
